uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, at least 4.
REQ-003 Parameter DATA_W, default 8, byte width; equals the S_WIDTH of the upstream parallel-to-serial stage.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  DATA_W  byte from the upstream stage (its serial_out).
REQ-007 din_valid  input  1  din is written this cycle (the upstream valid); there is no backpressure.
REQ-008 clr_overflow  input  1  single-cycle pulse that clears overflow.
REQ-009 tx  output  1  UART line, 8N1, idle high.
REQ-010 busy  output  1  high while the transmitter is in any state other than IDLE.
REQ-011 fifo_count  output  $clog2(DEPTH+1)  current number of FIFO entries.
REQ-012 overflow  output  1  sticky flag; set when a write is dropped.

Function
REQ-013 Each cycle with din_valid=1 and fifo_count<DEPTH, din is written at the tail of the FIFO.
REQ-014 A write attempted with fifo_count==DEPTH is dropped and sets overflow, even when a read happens in the same cycle.
REQ-015 A simultaneous write and read leaves fifo_count unchanged; the read returns the oldest entry.
REQ-016 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no gap.
REQ-017 If clr_overflow and a new overflow event occur in the same cycle, the set wins.
REQ-018 The transmitter FSM has four states: IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1. When fifo_count>0, the FSM reads one entry into the shift register and moves to START on the same edge.
REQ-020 START: tx=0 for exactly CLKS_PER_BIT cycles, then moves to DATA with bit index 0.
REQ-021 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first; after bit DATA_W-1 it moves to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles, then moves to IDLE.
REQ-023 IDLE always lasts at least one cycle, so back-to-back frames have a stop length of CLKS_PER_BIT+1 cycles.
REQ-024 tx is registered; a write at edge N into an empty FIFO with the FSM in IDLE gives a tx falling edge at N+2.
REQ-025 The baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, and resets to 0 on every state change.
REQ-026 A 3-byte burst from the upstream stage (3 consecutive cycles) is transmitted in arrival order; for a 24-bit word the MSB byte goes first.

Reset
REQ-027 While rst is high: tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0, baud and bit counters=0.
REQ-028 A reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously) and discards all FIFO contents.
REQ-029 FIFO storage contents are not reset; only pointers and count are.

Structure
REQ-030 Package uart_pkg holds the FSM state encoding (2-bit localparams) and the default CLKS_PER_BIT.
REQ-031 Storage and pointers live in one sub-module, sync_fifo (params DATA_W, DEPTH; ports wr_en, din, rd_en, dout, count, full, empty). uart_tx_fifo owns the FSM and the overflow logic.
REQ-032 dout of sync_fifo is combinational from the read pointer (first-word fall-through).

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-033 Single byte 0xA5 -> tx 1 start bit (0), data 1,0,1,0,0,1,0,1, stop bit (1), each held 4 cycles; falling edge 2 edges after the write; busy high 40 cycles.
REQ-034 Burst 0x12,0x34,0x56 on 3 consecutive cycles -> three frames in that order; fifo_count peaks at 2 or 3; 1 idle cycle between frames.
REQ-035 Six consecutive writes 0x01..0x06 while transmitting -> 0x05 and 0x06 dropped; overflow=1 until a clr_overflow pulse; frames 0x01..0x04 sent.
REQ-036 clr_overflow in the same cycle as a dropped write -> overflow remains 1.
REQ-037 rst asserted during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 at once, fifo_count=0, busy=0; no frame after release until a new write.
REQ-038 20 writes paced at one per frame -> pointers wrap several times; every byte is received intact by a bench UART monitor.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding and default bit timing.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    START = ST_START_ENC,
    DATA  = ST_DATA_ENC,
    STOP  = ST_STOP_ENC
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; count updates one cycle after wr/rd.
// Writes when full and reads when empty are ignored; storage itself is not reset.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign w_wr  = wr_en && !full;
  assign w_rd  = rd_en && !empty;
  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: write-to-start-bit latency 2 cycles, tx registered.
// No backpressure: writes into a full FIFO are dropped and latch a sticky overflow flag.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          din,
  input  logic                       din_valid,
  input  logic                       clr_overflow,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_overflow;

  logic [DATA_W-1:0] w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_rd;
  logic              w_baud_end;

  assign w_rd       = (r_state == IDLE) && !w_empty;
  assign w_baud_end = (r_baud == BAUD_MAX);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (din_valid),
    .din   (din),
    .rd_en (w_rd),
    .dout  (w_dout),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Full is judged before any same-cycle read, so a read never rescues the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_overflow <= 1'b0;
    else if (din_valid && w_full) r_overflow <= 1'b1;
    else if (clr_overflow)      r_overflow <= 1'b0;
  end

  // tx is driven from the current state, so the line trails the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_rd) begin
            r_shift <= w_dout;
            r_baud  <= '0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_MAX) begin
              r_bit   <= '0;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_baud  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4 and a line-level UART receiver.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          tx;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  int            n_checks = 0;
  int            n_errors = 0;
  int            frame_err = 0;
  logic [7:0]    rx_q [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .DATA_W       (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .clr_overflow (clr_overflow),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int c;
    c = 0;
    while ((busy || fifo_count != 3'd0) && c < lim) begin
      tick();
      c++;
    end
    check("idle_timeout", (c < lim), 1);
    repeat (2) tick();
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Expected line level k edges after the write into an idle, empty FIFO.
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int j;
    if (k < 2) return 1'b1;
    j = (k - 2) / 4;
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    return 1'b1;
  endfunction

  // Receiver: samples each bit near its middle, discards frames touched by reset.
  initial begin : uart_mon
    logic [7:0] b;
    logic       ab;
    logic       sb;
    logic       eb;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ab = 1'b0;
        @(negedge clk);
        if (rst) ab = 1'b1;
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          for (int w = 0; w < CPB; w++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          b[i] = tx;
        end
        for (int w = 0; w < CPB; w++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        eb = tx;
        if (!ab) begin
          rx_q.push_back(b);
          if (sb !== 1'b0 || eb !== 1'b1) frame_err++;
        end
      end
    end
  end

  initial begin : main
    logic [7:0] burst [3];
    logic [7:0] pv [20];
    int         exp_cnt [6];
    logic       bh [0:140];
    logic       th [0:140];
    int         peak;
    int         c;
    int         bad;

    burst   = '{8'h12, 8'h34, 8'h56};
    exp_cnt = '{1, 2, 3, 4, 4, 4};

    // Reset state
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // Single byte 0xA5
    rx_q.delete();
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("a5_count", fifo_count, 1);
    c = 0;
    for (int k = 1; k <= 46; k++) begin
      tick();
      check($sformatf("a5_tx_k%0d", k), tx, exp_tx(8'hA5, k));
      if (busy) c++;
    end
    check("a5_busy_cycles", c, 40);
    check("a5_rx_n", rx_q.size(), 1);
    check("a5_rx", rx_at(0), 32'hA5);

    // Burst of three on consecutive cycles
    rx_q.delete();
    peak = 0;
    for (int k = 0; k <= 135; k++) begin
      if (k < 3) begin
        din = burst[k];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      tick();
      bh[k] = busy;
      th[k] = tx;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_peak", (peak >= 2 && peak <= 3), 1);
    check("burst_busy40", bh[40], 1);
    check("burst_gap1", bh[41], 0);
    check("burst_busy42", bh[42], 1);
    check("burst_gap2", bh[82], 0);
    check("burst_busy122", bh[122], 1);
    check("burst_done", bh[123], 0);
    check("burst_stop_idle", th[42], 1);
    check("burst_start2", th[43], 0);
    wait_idle(50);
    check("burst_rx_n", rx_q.size(), 3);
    check("burst_rx0", rx_at(0), 32'h12);
    check("burst_rx1", rx_at(1), 32'h34);
    check("burst_rx2", rx_at(2), 32'h56);

    // Overflow: six writes while a frame is in flight; clear collides with last drop
    rx_q.delete();
    din = 8'h77; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      din = 8'(k + 1);
      din_valid = 1'b1;
      clr_overflow = (k == 5);
      tick();
      check($sformatf("ovf_count_w%0d", k + 1), fifo_count, exp_cnt[k]);
      check($sformatf("ovf_flag_w%0d", k + 1), overflow, (k >= 4));
    end
    din_valid = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_idle(400);
    check("ovf_rx_n", rx_q.size(), 5);
    check("ovf_rx0", rx_at(0), 32'h77);
    check("ovf_rx1", rx_at(1), 32'h01);
    check("ovf_rx2", rx_at(2), 32'h02);
    check("ovf_rx3", rx_at(3), 32'h03);
    check("ovf_rx4", rx_at(4), 32'h04);

    // Reset during data bit 3 of 0xFF with two bytes queued
    rx_q.delete();
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din = 8'h11;
    tick();
    din = 8'h22;
    tick();
    din_valid = 1'b0;
    repeat (17) tick();
    check("mid_busy", busy, 1);
    check("mid_count", fifo_count, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_count", fifo_count, 0);
    repeat (5) tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_rx_n", rx_q.size(), 0);

    // Twenty paced writes: pointers wrap five times
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      pv[i] = 8'(i * 29 + 90);
      din = pv[i];
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      wait_idle(100);
    end
    check("pace_rx_n", rx_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("pace_rx%0d", i), rx_at(i), {24'h0, pv[i]});
    end
    check("frame_errors", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
